// File: rtl/unroller_pkg.sv
// unroller_pkg
// Shared helpers for the unroller: derives the beat count per vector and the
// width of the beat counter from the top-level parameters.
// No ports (package).
package unroller_pkg;

    // Number of input beats that make up one assembled output vector.
    function automatic int beats_per_vector(input int num, input int roll_num);
        return num / roll_num;
    endfunction

    // Counter wide enough to hold 0..cycles-1 with one spare bit of headroom.
    function automatic int counter_width(input int cycles);
        return $clog2(cycles) + 32'sd1;
    endfunction

endpackage

// File: rtl/unroller_checker.sv
// unroller_checker
// Verification-only companion for unroller: while the output vector is held
// (data_out_valid high, data_out_ready low) the vector must stay valid and
// unchanged on the following cycle.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   data_out_valid  vector valid from the unroller
//   data_out_ready  vector ready into the unroller
//   data_out        assembled vector from the unroller
module unroller_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM        = 8
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  data_out_valid,
    input logic                  data_out_ready,
    input logic [DATA_WIDTH-1:0] data_out [NUM]
);

    logic [DATA_WIDTH*NUM-1:0] flat;
    logic [DATA_WIDTH*NUM-1:0] held;
    logic                      stalled;

    // Pack the output array so it can be compared in one expression.
    always_comb begin
        flat = {(DATA_WIDTH*NUM){1'b0}};
        for (int i = 0; i < NUM; i++) begin
            flat[i*DATA_WIDTH +: DATA_WIDTH] = data_out[i];
        end
    end

    // Remember the previous vector and whether it was stalled, then check it held.
    always_ff @(posedge clk) begin
        if (!rst && stalled) begin
            assert (data_out_valid && (flat == held))
            else $error("unroller held output changed while stalled");
        end
        stalled <= !rst && data_out_valid && !data_out_ready;
        held    <= flat;
    end

endmodule

// File: rtl/unroller.sv
// unroller
// Collects a stream of ROLL_NUM-element beats into one NUM-element vector.
// Beat k lands in data_out[k*ROLL_NUM +: ROLL_NUM]. The first CYCLES-1 beats
// are parked in a collection buffer; the last beat is merged with the buffer
// straight into the output slot, so the next vector can be collected while
// the current one waits to be drained.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   data_in         input beat (ROLL_NUM elements)
//   data_in_valid   beat valid
//   data_in_ready   beat accepted when valid && ready
//   data_out        assembled vector (NUM elements), registered
//   data_out_valid  vector valid, registered
//   data_out_ready  vector consumed when valid && ready
module unroller
    import unroller_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM        = 8,
    parameter int ROLL_NUM   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [ROLL_NUM],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [NUM],
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    localparam int CYCLES = beats_per_vector(NUM, ROLL_NUM);

    logic                  is_last;
    logic                  accept;
    logic                  consume;
    logic [DATA_WIDTH-1:0] assembled [NUM];

    // Only the last beat can be blocked, and only by a full slot that is not
    // being drained this cycle.
    assign data_in_ready = !is_last || !data_out_valid || data_out_ready;
    assign accept        = data_in_valid && data_in_ready;
    assign consume       = data_out_valid && data_out_ready;

    generate
        if (CYCLES > 1) begin : g_buf
            localparam int             CW      = counter_width(CYCLES);
            localparam int             BUF_LEN = NUM - ROLL_NUM;
            localparam logic [CW-1:0]  LAST    = CW'(CYCLES - 1);

            logic [CW-1:0]         counter;
            logic [DATA_WIDTH-1:0] buffer [BUF_LEN];

            assign is_last = (counter == LAST);

            // Beat counter and collection buffer; the last beat bypasses the buffer.
            always_ff @(posedge clk) begin
                if (rst) begin
                    counter <= {CW{1'b0}};
                    for (int i = 0; i < BUF_LEN; i++) begin
                        buffer[i] <= {DATA_WIDTH{1'b0}};
                    end
                end else if (accept) begin
                    if (is_last) begin
                        counter <= {CW{1'b0}};
                    end else begin
                        counter <= counter + CW'(32'd1);
                        for (int k = 0; k < CYCLES - 1; k++) begin
                            if (counter == CW'(k)) begin
                                for (int j = 0; j < ROLL_NUM; j++) begin
                                    buffer[k*ROLL_NUM + j] <= data_in[j];
                                end
                            end
                        end
                    end
                end
            end

            // Full vector as it will be loaded: buffered beats below, live beat on top.
            always_comb begin
                for (int i = 0; i < BUF_LEN; i++) begin
                    assembled[i] = buffer[i];
                end
                for (int j = 0; j < ROLL_NUM; j++) begin
                    assembled[BUF_LEN + j] = data_in[j];
                end
            end
        end else begin : g_slice
            // One beat per vector: every beat is the last, the block is a register slice.
            assign is_last = 1'b1;

            // The live beat is the whole vector.
            always_comb begin
                for (int j = 0; j < NUM; j++) begin
                    assembled[j] = data_in[j];
                end
            end
        end
    endgenerate

    // Output slot: loads on the last beat, clears valid on drain, keeps data otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_valid <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                data_out[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (accept && is_last) begin
            data_out_valid <= 1'b1;
            for (int i = 0; i < NUM; i++) begin
                data_out[i] <= assembled[i];
            end
        end else if (consume) begin
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= data_out_valid;
        end
    end

endmodule
